// File: rtl/coffee_input_conditioner.sv
// Synchronises and debounces the seven board switches and push-button A for the coffee machine.
// Outputs clean levels, a one-cycle press strobe for A, and a registered volume/bean validity flag.
module coffee_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int A_ACTIVE_LOW    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A_raw,
  input  logic [6:0] SW_raw,
  output logic [6:0] SW,
  output logic       A_level,
  output logic       A_pulse,
  output logic       VL,
  output logic       VL_chg
);

  localparam int              NCH      = 8;
  localparam logic            A_IDLE   = (A_ACTIVE_LOW != 0);
  localparam logic [NCH-1:0]  SYNC_RST = {A_IDLE, 7'b0};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 7 carries A; channels 6..0 carry the switches in pin order.
  logic [NCH-1:0]   s1_q;
  logic [NCH-1:0]   s2_q;
  logic [NCH-1:0]   samp;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic             a_level_dly_q;
  logic             vl_q;
  logic             vl_d;
  logic             vl_dly_q;

  assign samp = {s2_q[7] ^ A_IDLE, s2_q[6:0]};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = samp[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Valid when the volume selection matches the bean selection bit for bit.
  assign vl_d = (stable_q[3] == stable_q[5]) && (stable_q[4] == stable_q[6]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q          <= SYNC_RST;
      s2_q          <= SYNC_RST;
      stable_q      <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      a_level_dly_q <= 1'b0;
      vl_q          <= 1'b1;
      vl_dly_q      <= 1'b1;
    end else begin
      s1_q          <= {A_raw, SW_raw};
      s2_q          <= s1_q;
      stable_q      <= stable_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      a_level_dly_q <= stable_q[7];
      vl_q          <= vl_d;
      vl_dly_q      <= vl_q;
    end
  end

  assign SW      = stable_q[6:0];
  assign A_level = stable_q[7];
  assign A_pulse = stable_q[7] & ~a_level_dly_q;
  assign VL      = vl_q;
  assign VL_chg  = vl_q ^ vl_dly_q;

endmodule
